// File: rtl/alu_serial_ctrl.sv
// alu_serial_ctrl: bit-serial ALU sequencer.
// Runs one WIDTH-bit ALU operation over WIDTH clocks through a single
// bitslice, LSB first. It owns the operand and result shift registers,
// the carry flop, the bit counter and the start/busy/done handshake.
module alu_serial_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] r_sr_q, r_sr_d;
    logic [2:0]       op_q, op_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;

    logic             slice_cin;
    logic             slice_b_eff;
    logic             slice_fout;
    logic             slice_cout;
    logic             arith;
    logic [WIDTH-1:0] r_final;

    // Single ALU bitslice: ctrl picks add / or / and / invert, mode inverts B
    // (or picks B for the invert op); logic ops pass the carry straight through.
    always_comb begin
        arith       = (op_q[2:1] == 2'b00);
        slice_cin   = arith ? carry_q : op_q[0];
        slice_b_eff = b_sr_q[0] ^ op_q[0];
        slice_fout  = 1'b0;
        slice_cout  = slice_cin;
        case (op_q[2:1])
            2'b00: begin
                slice_fout = a_sr_q[0] ^ slice_b_eff ^ slice_cin;
                slice_cout = (a_sr_q[0] & slice_b_eff) |
                             (slice_cin & (a_sr_q[0] ^ slice_b_eff));
            end
            2'b01:   slice_fout = a_sr_q[0] | slice_b_eff;
            2'b10:   slice_fout = a_sr_q[0] & slice_b_eff;
            default: slice_fout = op_q[0] ? ~b_sr_q[0] : ~a_sr_q[0];
        endcase
        r_final = {slice_fout, r_sr_q[WIDTH-1:1]};
    end

    // Sequencer: accept in IDLE, shift one bit per clock in RUN, publish the
    // result and flags on the last bit, then spend one cycle in DONE.
    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        r_sr_d   = r_sr_q;
        op_d     = op_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        neg_d    = neg_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_sr_d  = a_in;
                    b_sr_d  = b_in;
                    op_d    = op;
                    carry_d = op[0];
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                a_sr_d  = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d  = {1'b0, b_sr_q[WIDTH-1:1]};
                r_sr_d  = r_final;
                carry_d = slice_cout;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d  = ST_DONE;
                    result_d = r_final;
                    cout_d   = arith & slice_cout;
                    ovf_d    = arith & (carry_q ^ slice_cout);
                    zero_d   = (r_final == '0);
                    neg_d    = slice_fout;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State register with asynchronous active-low reset that aborts any operation.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            r_sr_q   <= '0;
            op_q     <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            r_sr_q   <= r_sr_d;
            op_q     <= op_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
        end
    end

    assign busy   = (state_q != ST_IDLE);
    assign done   = (state_q == ST_DONE);
    assign result = result_q;
    assign cout   = cout_q;
    assign ovf    = ovf_q;
    assign zero   = zero_q;
    assign neg    = neg_q;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// tb_alu_serial_ctrl: scoreboard bench for the bit-serial ALU sequencer.
// A reference model predicts accepted operations and their results from
// whole-word arithmetic; a monitor on the falling edge checks the handshake
// every cycle and pops the scoreboard whenever done is seen.
module tb_alu_serial_ctrl;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] r;
        logic         c;
        logic         v;
        logic         z;
        logic         n;
        int           done_edge;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;
    logic         zero;
    logic         neg;

    exp_t sb_q[$];
    exp_t held;
    int   edge_num  = 0;
    int   acc_edge  = 0;
    logic acc_valid = 1'b0;
    int   n_vec     = 0;
    int   n_fail    = 0;

    alu_serial_ctrl #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .a_in    (a_in),
        .b_in    (b_in),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .cout    (cout),
        .ovf     (ovf),
        .zero    (zero),
        .neg     (neg)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Whole-word reference for every opcode, including flags.
    function automatic exp_t ref_model(input logic [2:0] o, input logic [W-1:0] a,
                                       input logic [W-1:0] b, input int de);
        exp_t       e;
        logic [W:0] s;
        e.c = 1'b0;
        e.v = 1'b0;
        case (o)
            3'd0: begin
                s   = {1'b0, a} + {1'b0, b};
                e.r = s[W-1:0];
                e.c = s[W];
                e.v = (a[W-1] == b[W-1]) && (e.r[W-1] != a[W-1]);
            end
            3'd1: begin
                s   = {1'b0, a} + {1'b0, ~b} + 1;
                e.r = s[W-1:0];
                e.c = s[W];
                e.v = (a[W-1] != b[W-1]) && (e.r[W-1] != a[W-1]);
            end
            3'd2:    e.r = a | b;
            3'd3:    e.r = a | ~b;
            3'd4:    e.r = a & b;
            3'd5:    e.r = a & ~b;
            3'd6:    e.r = ~a;
            default: e.r = ~b;
        endcase
        e.z         = (e.r == '0);
        e.n         = e.r[W-1];
        e.done_edge = de;
        return e;
    endfunction

    task automatic check_output(input string name, input logic [W-1:0] act,
                                input logic [W-1:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)",
                     name, act, exp_v, edge_num);
        end
    endtask

    // Model: an operation is accepted only when WIDTH+2 edges have passed
    // since the previous acceptance; its done is due WIDTH edges later.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_valid <= 1'b0;
            sb_q.delete();
        end else begin
            edge_num <= edge_num + 1;
            if (start && (!acc_valid || (edge_num + 1 - acc_edge) >= W + 2)) begin
                sb_q.push_back(ref_model(op, a_in, b_in, edge_num + 1 + W));
                acc_valid <= 1'b1;
                acc_edge  <= edge_num + 1;
            end
        end
    end

    // Monitor: checks handshake each cycle, scores results on done and
    // otherwise requires the previous outputs to be held.
    always @(negedge clk) begin
        if (!reset_n) begin
            check_output("busy_in_reset", W'(busy), '0);
            check_output("done_in_reset", W'(done), '0);
            check_output("result_in_reset", result, '0);
            check_output("flags_in_reset", W'({cout, ovf, zero, neg}), '0);
            held = ref_model(3'd4, '0, '0, 0);
            held.z = 1'b0;
        end else begin
            check_output("busy", W'(busy),
                         W'(acc_valid && (edge_num - acc_edge) <= W));
            check_output("done", W'(done),
                         W'(acc_valid && (edge_num - acc_edge) == W));
            if (done) begin
                if (sb_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("[TB] FAIL done_spurious: got done=1, expected no pending op (edge %0d)",
                             edge_num);
                end else begin
                    held = sb_q.pop_front();
                    check_output("result", result, held.r);
                    check_output("cout", W'(cout), W'(held.c));
                    check_output("ovf", W'(ovf), W'(held.v));
                    check_output("zero", W'(zero), W'(held.z));
                    check_output("neg", W'(neg), W'(held.n));
                end
            end else begin
                check_output("result_hold", result, held.r);
                check_output("flags_hold", W'({cout, ovf, zero, neg}),
                             W'({held.c, held.v, held.z, held.n}));
            end
            while (sb_q.size() != 0 && sb_q[0].done_edge < edge_num) begin
                n_vec++;
                n_fail++;
                $display("[TB] FAIL done_missing: got no done, expected done at edge %0d", sb_q[0].done_edge);
                void'(sb_q.pop_front());
            end
        end
    end

    // Issue one operation, then spend the rest of its slot with random
    // operand churn and optional stray start pulses.
    task automatic apply_stimulus(input logic [2:0] o, input logic [W-1:0] a,
                                  input logic [W-1:0] b, input bit noisy);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a_in  = a;
        b_in  = b;
        for (int k = 1; k <= W + 1; k++) begin
            @(negedge clk);
            start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            op    = 3'($urandom);
            a_in  = W'($urandom);
            b_in  = W'($urandom);
        end
    endtask

    logic [2:0]   d_op [14] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd2, 3'd3,
                                3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd0};
    logic [W-1:0] d_a  [14] = '{8'h7F, 8'hFF, 8'h05, 8'h03, 8'h80, 8'hF0, 8'hF0,
                                8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'h00, 8'h00, 8'h80};
    logic [W-1:0] d_b  [14] = '{8'h01, 8'h01, 8'h05, 8'h05, 8'h01, 8'h3C, 8'h3C,
                                8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h00, 8'h00, 8'h80};

    // Main sequence: reset, directed vectors, mid-run reset, held start, random ops.
    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        op      = '0;
        a_in    = '0;
        b_in    = '0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 reset_n = 1'b1;

        for (int i = 0; i < 14; i++)
            apply_stimulus(d_op[i], d_a[i], d_b[i], (i % 2) == 1);

        $display("[TB] reset during RUN");
        @(negedge clk);
        start = 1'b1;
        op    = 3'd0;
        a_in  = 8'h12;
        b_in  = 8'h34;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check_output("busy_async_reset", W'(busy), '0);
        check_output("done_async_reset", W'(done), '0);
        check_output("result_async_reset", result, '0);
        check_output("flags_async_reset", W'({cout, ovf, zero, neg}), '0);
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        apply_stimulus(3'd0, 8'h12, 8'h34, 1'b0);

        $display("[TB] start held high");
        @(negedge clk);
        for (int k = 0; k < 45; k++) begin
            start = 1'b1;
            op    = 3'($urandom);
            a_in  = W'($urandom);
            b_in  = W'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        repeat (W + 3) @(negedge clk);

        $display("[TB] random operations");
        for (int i = 0; i < 40; i++)
            apply_stimulus(3'($urandom), W'($urandom), W'($urandom), 1'b1);

        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 4 * W && sb_q.size() != 0; k++)
            @(negedge clk);
        if (sb_q.size() != 0) begin
            n_vec++;
            n_fail++;
            $display("[TB] FAIL drain: got %0d pending ops, expected 0", sb_q.size());
        end
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
